// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime divisor, optional parity, glitch-rejecting start and FWFT receive FIFO.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling around mid-bit (needs cfg_divisor >= 5).
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int DIV_W      = 12,
   parameter int FIFO_DEPTH = 4,
   parameter int RTS_LEVEL  = 3
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        uart_rxd,
   output logic                        uart_rts,
   input  logic [DIV_W-1:0]            cfg_divisor,
   input  logic [1:0]                  cfg_parity,
   input  logic                        rx_read,
   output logic                        rx_valid,
   output logic [DATA_BITS-1:0]        rx_data,
   output logic                        rx_frame_err,
   output logic                        rx_parity_err,
   output logic [$clog2(FIFO_DEPTH):0] rx_level,
   output logic                        overrun,
   input  logic                        overrun_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(DATA_BITS);
   localparam int EW = DATA_BITS + 2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;

   function automatic logic parity_err_f(input logic acc, input logic pbit, input logic [1:0] mode);
      return acc ^ pbit ^ (mode == 2'd2);
   endfunction

`ifdef UART_RX_MAJORITY_EN
   function automatic logic maj3_f(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
`endif

   logic                 rxd_p0, rxd_p1, rxs;
   logic [2:0]           state;
   logic [DIV_W-1:0]     cnt, div_q, half;
   logic [1:0]           par_q;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_acc, par_err_q;
   logic                 at_end, samp_evt, samp_val, par_en;
   logic                 push, pop, do_push, ovr_set, full;
   logic [EW-1:0]        push_word, head;
   logic [EW-1:0]        mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [LW-1:0]        lvl;

   // Input synchroniser: line idles high
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rxd_p0 <= 1'b1;
         rxd_p1 <= 1'b1;
      end else begin
         rxd_p0 <= uart_rxd;
         rxd_p1 <= rxd_p0;
      end
   end
   assign rxs = rxd_p1;

   assign half   = div_q >> 1;
   assign at_end = (cnt == div_q);
   assign par_en = (par_q == 2'd1) || (par_q == 2'd2);

`ifdef UART_RX_MAJORITY_EN
   logic smp_m1, smp_c;
   always_ff @(posedge clk) begin
      if (cnt == half - DIV_W'(1)) smp_m1 <= rxs;
      if (cnt == half)             smp_c  <= rxs;
   end
   assign samp_evt = (cnt == half + DIV_W'(1));
   assign samp_val = maj3_f(smp_m1, smp_c, rxs);
`else
   assign samp_evt = (cnt == half);
   assign samp_val = rxs;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         div_q   <= '0;
         par_q   <= 2'd0;
         bit_idx <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (!rxs) begin
                  state <= ST_START;
                  div_q <= cfg_divisor;
                  par_q <= cfg_parity;
               end
            end
            ST_START: begin
               if (samp_evt && samp_val) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (at_end) begin
                  state   <= ST_DATA;
                  cnt     <= '0;
                  bit_idx <= '0;
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            ST_DATA: begin
               if (at_end) begin
                  cnt <= '0;
                  if (bit_idx == BW'(DATA_BITS - 1)) state <= par_en ? ST_PARITY : ST_STOP;
                  else bit_idx <= bit_idx + BW'(1);
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            ST_PARITY: begin
               if (at_end) begin
                  state <= ST_STOP;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            ST_STOP: begin
               // Leave at mid-stop so a following start bit is not missed
               if (samp_evt) begin
                  state <= samp_val ? ST_IDLE : ST_BREAK;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            ST_BREAK: begin
               cnt <= '0;
               if (rxs) state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      case (state)
         ST_START: begin
            par_acc   <= 1'b0;
            par_err_q <= 1'b0;
         end
         ST_DATA: if (samp_evt) begin
            shreg   <= {samp_val, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ samp_val;
         end
         ST_PARITY: if (samp_evt) par_err_q <= parity_err_f(par_acc, samp_val, par_q);
         default: ;
      endcase
   end

   assign push      = (state == ST_STOP) && samp_evt;
   assign push_word = {~samp_val, par_err_q, shreg};

   // Receive FIFO: a pop in the same cycle frees room for a push into a full FIFO
   assign full    = (lvl == LW'(FIFO_DEPTH));
   assign rx_valid = (lvl != '0);
   assign pop     = rx_read && rx_valid;
   assign do_push = push && (!full || pop);
   assign ovr_set = push && full && !pop;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         lvl      <= '0;
         overrun  <= 1'b0;
         uart_rts <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, pop})
            2'b10:   lvl <= lvl + LW'(1);
            2'b01:   lvl <= lvl - LW'(1);
            default: lvl <= lvl;
         endcase
         if (ovr_set)          overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
         uart_rts <= (lvl >= LW'(RTS_LEVEL));
      end
   end

   assign head          = mem[rd_ptr];
   assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
   assign rx_parity_err = rx_valid ? head[DATA_BITS]     : 1'b0;
   assign rx_frame_err  = rx_valid ? head[DATA_BITS+1]   : 1'b0;
   assign rx_level      = lvl;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected entries, a monitor pops and compares.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        uart_rxd = 1'b1;
   logic        uart_rts;
   logic [11:0] cfg_divisor = 12'd3;
   logic [1:0]  cfg_parity = 2'd0;
   logic        rx_read = 1'b0;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_frame_err;
   logic        rx_parity_err;
   logic [2:0]  rx_level;
   logic        overrun;
   logic        overrun_clr = 1'b0;

   int         n_vec = 0;
   int         n_err = 0;
   bit         rd_en = 1'b0;
   logic [9:0] exp_q[$];

   uart_rx_fifo dut (
      .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rts(uart_rts),
      .cfg_divisor(cfg_divisor), .cfg_parity(cfg_parity), .rx_read(rx_read),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_frame_err(rx_frame_err),
      .rx_parity_err(rx_parity_err), .rx_level(rx_level), .overrun(overrun),
      .overrun_clr(overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic expect_char(input logic [7:0] d, input logic fe, input logic pe);
      exp_q.push_back({fe, pe, d});
   endtask

   task automatic hold(input logic b, input int div);
      uart_rxd = b;
      repeat (div + 1) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int div, input bit par,
                             input logic pbit, input logic stopb);
      hold(1'b0, div);
      for (int i = 0; i < 8; i++) hold(d[i], div);
      if (par) hold(pbit, div);
      hold(stopb, div);
      uart_rxd = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: %0d entries still expected", exp_q.size());
      end
      repeat (2) @(negedge clk);
   endtask

   // Monitor: pops the FIFO head when reading is enabled and compares with the scoreboard
   initial begin
      logic [9:0] e;
      forever begin
         @(negedge clk);
         rx_read = 1'b0;
         if (rd_en && resetn && rx_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_entry: got 0x%0h expected none",
                        {rx_frame_err, rx_parity_err, rx_data});
            end else begin
               e = exp_q.pop_front();
               chk("rx_entry", 32'({rx_frame_err, rx_parity_err, rx_data}), 32'(e));
            end
            rx_read = 1'b1;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_rts",     32'(uart_rts), 32'd1);
      chk("rst_valid",   32'(rx_valid), 32'd0);
      chk("rst_level",   32'(rx_level), 32'd0);
      chk("rst_overrun", 32'(overrun),  32'd0);
      chk("rst_data",    32'(rx_data),  32'd0);
      chk("rst_errs",    32'({rx_frame_err, rx_parity_err}), 32'd0);
      resetn = 1'b1;
      repeat (5) @(negedge clk);

      // Basic receive, div 3, no parity
      cfg_divisor = 12'd3;
      cfg_parity  = 2'd0;
      expect_char(8'hA5, 1'b0, 1'b0);
      send_frame(8'hA5, 3, 1'b0, 1'b0, 1'b1);
      repeat (6) @(negedge clk);
      chk("basic_level", 32'(rx_level), 32'd1);
      chk("basic_valid", 32'(rx_valid), 32'd1);
      chk("basic_rts",   32'(uart_rts), 32'd0);
      rd_en = 1'b1;
      wait_drain(20);
      chk("basic_empty", 32'(rx_valid), 32'd0);

      // Odd parity, div 7: 0x3C has four ones, so parity bit 1 is correct
      cfg_divisor = 12'd7;
      cfg_parity  = 2'd2;
      expect_char(8'h3C, 1'b0, 1'b0);
      expect_char(8'h3C, 1'b0, 1'b1);
      send_frame(8'h3C, 7, 1'b1, 1'b1, 1'b1);
      send_frame(8'h3C, 7, 1'b1, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      wait_drain(40);
      // Even parity on 0x07 (three ones) needs parity bit 1
      cfg_parity = 2'd1;
      expect_char(8'h07, 1'b0, 1'b0);
      send_frame(8'h07, 7, 1'b1, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      wait_drain(40);

      // Break: line low for 40 bit times gives exactly one framing-error entry
      cfg_divisor = 12'd3;
      cfg_parity  = 2'd0;
      expect_char(8'h00, 1'b1, 1'b0);
      uart_rxd = 1'b0;
      repeat (40 * 4) @(negedge clk);
      chk("break_level", 32'(rx_level), 32'd0);
      uart_rxd = 1'b1;
      repeat (10) @(negedge clk);
      wait_drain(20);
      chk("break_idle_level", 32'(rx_level), 32'd0);

      // Glitch rejection at div 15, then a normal character proves the receiver is idle again
      cfg_divisor = 12'd15;
      uart_rxd = 1'b0;
      repeat (4) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_level", 32'(rx_level), 32'd0);
      chk("glitch_valid", 32'(rx_valid), 32'd0);
      expect_char(8'h96, 1'b0, 1'b0);
      send_frame(8'h96, 15, 1'b0, 1'b0, 1'b1);
      repeat (15) @(negedge clk);
      wait_drain(20);

      // Overrun and RTS: five back-to-back characters into a 4-deep FIFO with no reads
      rd_en = 1'b0;
      cfg_divisor = 12'd3;
      for (int k = 1; k <= 4; k++) expect_char(8'(k), 1'b0, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         fork
            send_frame(8'(k), 3, 1'b0, 1'b0, 1'b1);
            begin
               if (k > 1) begin
                  repeat (4) @(negedge clk);
                  chk("ovr_level", 32'(rx_level), 32'(k - 1));
                  chk("ovr_rts",   32'(uart_rts), 32'((k - 1) >= 3));
                  chk("ovr_flag_before", 32'(overrun), 32'd0);
               end
            end
         join
      end
      repeat (10) @(negedge clk);
      chk("ovr_full_level", 32'(rx_level), 32'd4);
      chk("ovr_full_rts",   32'(uart_rts), 32'd1);
      chk("ovr_flag",       32'(overrun),  32'd1);
      rd_en = 1'b1;
      wait_drain(20);
      chk("ovr_sticky",  32'(overrun),  32'd1);
      chk("ovr_rts_low", 32'(uart_rts), 32'd0);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      chk("ovr_cleared", 32'(overrun), 32'd0);

      // Reset during data bit 4 with one entry already buffered
      rd_en = 1'b0;
      cfg_divisor = 12'd7;
      send_frame(8'h33, 7, 1'b0, 1'b0, 1'b1);
      repeat (8) @(negedge clk);
      chk("pre_rst_level", 32'(rx_level), 32'd1);
      hold(1'b0, 7);
      for (int i = 0; i < 4; i++) hold((i % 2) == 1, 7);
      uart_rxd = 1'b1;
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(rx_valid), 32'd0);
      chk("mid_rst_level", 32'(rx_level), 32'd0);
      chk("mid_rst_data",  32'(rx_data),  32'd0);
      chk("mid_rst_rts",   32'(uart_rts), 32'd1);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_level", 32'(rx_level), 32'd0);
      rd_en = 1'b1;
      expect_char(8'h5A, 1'b0, 1'b0);
      send_frame(8'h5A, 7, 1'b0, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      wait_drain(20);
      chk("final_level", 32'(rx_level), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Next-generation UART receiver for the tinyQV peripheral set.
- Adds a runtime baud divisor, optional parity checking, and glitch-rejecting start detection.
- Received characters go into a first-word-fall-through (FWFT) receive FIFO, each tagged with framing and parity error bits; overrun is reported as a sticky flag.
- Sits between the UART RX pin and the peripheral register bus; RTS flow control is driven from the FIFO fill level.

Parameters:
- DATA_BITS, 8: payload bits per character, LSB first; legal range 5..8.
- DIV_W, 12: width of cfg_divisor.
- FIFO_DEPTH, 4: receive FIFO entries; must be a power of two, at least 2.
- RTS_LEVEL, 3: fill level at or above which uart_rts is driven high (deasserted); range 1..FIFO_DEPTH.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- uart_rxd  in  1  UART receive pin, asynchronous to clk.
- uart_rts  out  1  request-to-send, active low; registered.
- cfg_divisor  in  DIV_W  cycles per bit minus 1; minimum legal value 3.
- cfg_parity  in  2  0 = none, 1 = even, 2 = odd, 3 = none.
- rx_read  in  1  pop the head FIFO entry.
- rx_valid  out  1  FIFO not empty.
- rx_data  out  DATA_BITS  head entry data.
- rx_frame_err  out  1  head entry had a low stop bit.
- rx_parity_err  out  1  head entry failed its parity check.
- rx_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overrun  out  1  sticky: a character was dropped because the FIFO was full.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset values: uart_rts = 1, rx_valid = 0, rx_level = 0, overrun = 0, rx_data = 0, error flags = 0. The two-flop synchroniser resets to 1 (line idle). Reset takes effect immediately at any point, including mid-character and mid-FIFO-operation; the partial character is discarded.
- Synchroniser: two flops; all logic uses the synchronised value, called rxs below.
- Divisor handling: cfg_divisor and cfg_parity are latched on the IDLE->START transition. Changes during a character have no effect until the next start bit.
- Bit counter: runs 0..div. mid = counter equals div/2 (integer divide). end = counter equals div; at end the counter returns to 0.
- IDLE: counter held at 0. If rxs = 0, go to START.
- START: at mid, if rxs = 1 it is a glitch: return to IDLE with no FIFO write and no flags set. Otherwise at end go to DATA with bit index 0.
- DATA: sample rxs at mid and shift it in LSB first. At end, increment the bit index. After bit DATA_BITS-1, go to PARITY if parity is enabled, else to STOP.
- PARITY: sample at mid. Even parity: the XOR of the data bits and the parity bit must be 0. Odd parity: it must be 1. Go to STOP at end.
- STOP: at mid, push {data, frame_err = ~rxs, parity_err}. If rxs = 1, go to IDLE immediately; this half-bit early exit allows back-to-back characters. If rxs = 0, go to BREAK.
- BREAK: wait for rxs = 1, then go to IDLE. No further pushes occur, so an all-zero line produces exactly one entry.
- FIFO: FWFT, so rx_data and the error flags show the head entry whenever rx_valid = 1.
  - rx_read while empty is ignored.
  - A push while full is dropped and sets overrun, unless rx_read is asserted in the same cycle; then both the pop and the push happen and the level is unchanged.
  - Simultaneous push and pop while not full leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- overrun: overrun_clr clears it. If overrun_clr and a new overrun occur in the same cycle, the set wins.
- uart_rts: registered, equal to (rx_level >= RTS_LEVEL), so it updates one cycle after the level changes.
- Latency: an entry is visible on rx_valid on the cycle after the STOP mid-sample, i.e. (div/2)+2 cycles after the synchronised stop bit begins.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each mid-bit sample (start, data, parity, stop) is the 2-of-3 majority of rxs at counter = div/2-1, div/2 and div/2+1, and the decision is taken at div/2+1. START glitch rejection uses the majority value. Requires cfg_divisor >= 5.
- Undefined: a single sample is taken at div/2, as described above.

Test Plan:
- Basic receive: div = 3, parity none, send 0xA5 with 1 stop bit -> rx_valid = 1, rx_data = 0xA5, both error flags 0, rx_level = 1. rx_read one cycle -> rx_valid = 0.
- Parity: div = 7, odd parity, send 0x3C with parity bit 1 -> parity_err = 0. Resend with parity bit 0 -> parity_err = 1, data still 0x3C.
- Framing and break: hold rxd low for 40 bit times -> exactly one entry {0x00, frame_err = 1}. No new start is detected until rxd returns high.
- Glitch rejection: div = 15, pulse rxd low for 4 cycles -> no entry, FSM back in IDLE, rx_level = 0.
- Overrun and RTS: FIFO_DEPTH = 4, RTS_LEVEL = 3, send 0x01..0x05 back-to-back with no reads -> uart_rts goes to 1 after the third character; 0x05 is dropped; overrun = 1. Reads return 0x01..0x04. overrun_clr -> overrun = 0.
- Reset mid-character: assert resetn = 0 during data bit 4 -> all outputs return to reset values immediately. After release, the next full character 0x5A is received correctly.
